writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Shares the single writeback/complete path between the N execute pipes: ALU, multiplier, load/store and control-flow.
- Sits between the execute units' X→W outputs and the writeback/commit logic.
- Each cycle, picks one valid pipe result with a round-robin arbiter and places it in a one-entry output pipeline register.
- Presents that register downstream with val/rdy handshake and backpressure.

Parameters:
- p_num_pipes, 4, number of execute pipes arbitrated; must be ≥ 2.
- p_seq_num_bits, 5, width of the instruction sequence number.
- p_phys_addr_bits, 6, width of the physical destination register index.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset; state clears on a rising clk edge while rst=0.
- ex_val  input  p_num_pipes  per-pipe result valid.
- ex_rdy  output  p_num_pipes  per-pipe accept; a transfer occurs when ex_val[i] & ex_rdy[i].
- ex_seq_num  input  p_num_pipes*p_seq_num_bits  per-pipe sequence number; pipe i occupies slice i.
- ex_preg  input  p_num_pipes*p_phys_addr_bits  per-pipe physical destination register.
- ex_waddr  input  p_num_pipes*5  per-pipe architectural destination register.
- ex_wdata  input  p_num_pipes*32  per-pipe result data.
- ex_wen  input  p_num_pipes  per-pipe write enable.
- ex_pc  input  p_num_pipes*32  per-pipe instruction PC.
- wb_val  output  1  output register valid.
- wb_rdy  input  1  downstream accept.
- wb_seq_num, wb_preg, wb_waddr, wb_wdata, wb_wen, wb_pc  output  matching widths  registered fields of the selected result.
- wb_src  output  p_num_pipes  one-hot index of the pipe that produced the current output.

Behaviour:
- State:
  - output register: valid bit plus all fields plus wb_src.
  - round-robin pointer ptr, width $clog2(p_num_pipes), values 0..p_num_pipes-1.
- Reset (rst=0 at a clk edge):
  - wb_val=0, ptr=0.
  - All wb_* data fields and wb_src reset to 0.
  - Overrides any in-flight transfer; a result held in the register is discarded.
  - While rst=0, ex_rdy = all zeros.
- can_accept = !wb_val | wb_rdy. The register accepts a new entry in the same cycle the old one drains: full throughput, 1 result/cycle.
- Grant (combinational):
  - Scan pipes starting at ptr in order ptr, ptr+1, … modulo p_num_pipes.
  - The first i with ex_val[i]=1 gets grant[i]=1; at most one grant per cycle.
  - ex_rdy[i] = grant[i] & can_accept.
  - ex_rdy must not depend on ex_val[i] except through the grant scan; there is no combinational path from wb_rdy to any ex_* field other than ex_rdy.
- On a transfer from pipe g:
  - The register loads pipe g's fields, wb_src = one-hot(g), wb_val=1.
  - ptr ← (g+1) mod p_num_pipes, including wrap from p_num_pipes-1 to 0.
- If wb_rdy=1, wb_val=1 and no pipe is valid: wb_val←0, ptr unchanged.
- If wb_val=1 and wb_rdy=0:
  - Register and ptr hold.
  - All ex_rdy=0.
  - wb_* fields must be stable while wb_val=1 and wb_rdy=0.
- Latency: a result accepted in cycle t appears on wb_* in cycle t+1.
- Fairness: with all pipes continuously valid and wb_rdy=1, grants rotate 0,1,2,3,0,… Any waiting pipe is served within p_num_pipes accepted transfers.
- ex_wen=0 results (stores, jumps without rd) are arbitrated and forwarded identically; the downstream logic interprets wen.
- No squash handling here; squash filtering is the downstream unit's responsibility.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined, adds:
  - output perf_grant_cnt (p_num_pipes*32): per-pipe count of accepted transfers.
  - output perf_stall_cnt (p_num_pipes*32): per-pipe count of cycles with ex_val[i]=1 & ex_rdy[i]=0.
- Counters reset to 0 under rst=0, wrap modulo 2^32, and do not affect arbitration.
- When not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - typedef wb_entry_t, a struct of seq_num, preg, waddr, wdata, wen and pc, parameterised by widths through localparams.
  - constant WB_ARCH_ADDR_BITS=5.
- One sub-module: rr_arbiter.
  - Parameter p_num_reqs.
  - Inputs: req vector, en, ptr update on grant.
  - Output: one-hot grant.
  - It owns ptr; writeback_arbiter owns the output register and handshake.

Test Plan:
- Reset then idle: rst=0 two cycles, ex_val=0 → wb_val=0, ex_rdy=0000, wb_src=0000; after rst=1 with ex_val=0010 → ex_rdy=0010 and wb_val=1 next cycle.
- Single pipe, ex_val=0100 with seq_num 7, wdata 0xDEADBEEF, wb_rdy=1 → next cycle wb_val=1, wb_seq_num=7, wb_wdata=0xDEADBEEF, wb_src=0100; ptr becomes 3.
- All four pipes valid continuously, wb_rdy=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3; wb_val=1 every cycle after the first.
- Backpressure with pipes 0 and 1 valid:
  - Hold wb_rdy=0 for 3 cycles → ex_rdy=0000 and wb_* stable.
  - Raise wb_rdy → same-cycle drain and refill; pipe 1 appears in the following cycle after pipe 0.
- Wrap-around: ptr=3 with ex_val=1001 → pipe 3 granted first, then ptr=0 and pipe 0 granted next.
- Mid-operation reset: wb_val=1, wb_rdy=0, ptr=2, assert rst=0 one cycle → wb_val=0, ptr=0; with WB_ARB_PERF_EN, all counters read 0.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_pkg
//   Shared types and constants for the writeback arbiter slice.
//   - WB_ARCH_ADDR_BITS : architectural register index width
//   - WB_SEQ_NUM_BITS   : default instruction sequence number width
//   - WB_PHYS_ADDR_BITS : default physical register index width
//   - WB_DATA_BITS      : result / PC width
//   - wb_entry_t        : one execute-pipe result as carried to writeback
// -----------------------------------------------------------------------------
package writeback_arbiter_pkg;

  localparam int unsigned WB_ARCH_ADDR_BITS = 5;
  localparam int unsigned WB_SEQ_NUM_BITS   = 5;
  localparam int unsigned WB_PHYS_ADDR_BITS = 6;
  localparam int unsigned WB_DATA_BITS      = 32;

  typedef struct packed {
    logic [WB_SEQ_NUM_BITS-1:0]   seq_num;
    logic [WB_PHYS_ADDR_BITS-1:0] preg;
    logic [WB_ARCH_ADDR_BITS-1:0] waddr;
    logic [WB_DATA_BITS-1:0]      wdata;
    logic                         wen;
    logic [WB_DATA_BITS-1:0]      pc;
  } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with an internal priority pointer. The grant is purely
//   combinational from req_i and the pointer; the pointer moves to one past
//   the winner only when en_i is high and a request was granted.
//
// Ports:
//   clk     - clock
//   rst     - synchronous active-low reset (pointer -> 0)
//   req_i   - request vector, one bit per requester
//   en_i    - grant is consumed this cycle; advance the pointer
//   grant_o - one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned p_num_reqs = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [p_num_reqs-1:0] req_i,
  input  logic                  en_i,
  output logic [p_num_reqs-1:0] grant_o
);

  localparam int unsigned PtrW = $clog2(p_num_reqs);

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;
  logic [PtrW-1:0] idx;
  logic [PtrW-1:0] win_ptr;
  logic [PtrW:0]   sum;
  logic            found;

  // Scan ptr, ptr+1, ... modulo p_num_reqs; the extra sum bit keeps the
  // modulo correct for non-power-of-two requester counts.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    win_ptr = ptr_q;
    sum     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      sum = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (sum >= (PtrW+1)'(p_num_reqs)) begin
        sum = sum - (PtrW+1)'(p_num_reqs);
      end
      idx = sum[PtrW-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        win_ptr      = (idx == PtrW'(p_num_reqs - 1)) ? '0 : idx + PtrW'(1);
      end
    end
    ptr_d = (en_i && found) ? win_ptr : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//   Shares the single writeback path between the execute pipes. Each cycle one
//   valid pipe result is picked round-robin and loaded into a one-entry output
//   register, which is presented downstream with a val/rdy handshake. The
//   register refills in the same cycle it drains (1 result/cycle).
//
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   ex_val/ex_rdy   - per-pipe result handshake (transfer on val & rdy)
//   ex_seq_num, ex_preg, ex_waddr, ex_wdata, ex_wen, ex_pc
//                   - per-pipe result fields, pipe i in slice i
//   wb_val/wb_rdy   - output register handshake
//   wb_seq_num, wb_preg, wb_waddr, wb_wdata, wb_wen, wb_pc
//                   - registered fields of the selected result
//   wb_src          - one-hot index of the pipe that produced the output
//
// Build option WB_ARB_PERF_EN adds per-pipe 32-bit counters:
//   perf_grant_cnt  - accepted transfers per pipe
//   perf_stall_cnt  - cycles with ex_val[i] & !ex_rdy[i] per pipe
// -----------------------------------------------------------------------------
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned p_num_pipes      = 4,
  parameter int unsigned p_seq_num_bits   = WB_SEQ_NUM_BITS,
  parameter int unsigned p_phys_addr_bits = WB_PHYS_ADDR_BITS
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [p_num_pipes-1:0]                    ex_val,
  output logic [p_num_pipes-1:0]                    ex_rdy,
  input  logic [p_num_pipes*p_seq_num_bits-1:0]     ex_seq_num,
  input  logic [p_num_pipes*p_phys_addr_bits-1:0]   ex_preg,
  input  logic [p_num_pipes*WB_ARCH_ADDR_BITS-1:0]  ex_waddr,
  input  logic [p_num_pipes*WB_DATA_BITS-1:0]       ex_wdata,
  input  logic [p_num_pipes-1:0]                    ex_wen,
  input  logic [p_num_pipes*WB_DATA_BITS-1:0]       ex_pc,
  output logic                                      wb_val,
  input  logic                                      wb_rdy,
  output logic [p_seq_num_bits-1:0]                 wb_seq_num,
  output logic [p_phys_addr_bits-1:0]               wb_preg,
  output logic [WB_ARCH_ADDR_BITS-1:0]              wb_waddr,
  output logic [WB_DATA_BITS-1:0]                   wb_wdata,
  output logic                                      wb_wen,
  output logic [WB_DATA_BITS-1:0]                   wb_pc,
  output logic [p_num_pipes-1:0]                    wb_src
`ifdef WB_ARB_PERF_EN
  ,
  output logic [p_num_pipes*32-1:0]                 perf_grant_cnt,
  output logic [p_num_pipes*32-1:0]                 perf_stall_cnt
`endif
);

  logic [p_num_pipes-1:0] grant;
  logic                   can_accept;
  logic                   transfer;

  wb_entry_t              sel;
  wb_entry_t              wb_q;
  wb_entry_t              wb_d;
  logic                   wb_val_q;
  logic                   wb_val_d;
  logic [p_num_pipes-1:0] wb_src_q;
  logic [p_num_pipes-1:0] wb_src_d;

  // The register can take a new entry when empty or draining this cycle.
  assign can_accept = !wb_val_q || wb_rdy;

  rr_arbiter #(
    .p_num_reqs (p_num_pipes)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_i   (ex_val),
    .en_i    (can_accept && rst),
    .grant_o (grant)
  );

  // Grant already implies ex_val, so any ex_rdy bit marks a transfer.
  always_comb begin
    ex_rdy   = (rst && can_accept) ? grant : '0;
    transfer = |ex_rdy;
  end

  // One-hot field mux for the granted pipe.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < p_num_pipes; i++) begin
      if (grant[i]) begin
        sel.seq_num = ex_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
        sel.preg    = ex_preg[i*p_phys_addr_bits +: p_phys_addr_bits];
        sel.waddr   = ex_waddr[i*WB_ARCH_ADDR_BITS +: WB_ARCH_ADDR_BITS];
        sel.wdata   = ex_wdata[i*WB_DATA_BITS +: WB_DATA_BITS];
        sel.wen     = ex_wen[i];
        sel.pc      = ex_pc[i*WB_DATA_BITS +: WB_DATA_BITS];
      end
    end
  end

  always_comb begin
    wb_d     = wb_q;
    wb_val_d = wb_val_q;
    wb_src_d = wb_src_q;
    if (transfer) begin
      wb_d     = sel;
      wb_val_d = 1'b1;
      wb_src_d = grant;
    end else if (wb_rdy) begin
      wb_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q     <= '0;
      wb_val_q <= 1'b0;
      wb_src_q <= '0;
    end else begin
      wb_q     <= wb_d;
      wb_val_q <= wb_val_d;
      wb_src_q <= wb_src_d;
    end
  end

  assign wb_val     = wb_val_q;
  assign wb_seq_num = wb_q.seq_num;
  assign wb_preg    = wb_q.preg;
  assign wb_waddr   = wb_q.waddr;
  assign wb_wdata   = wb_q.wdata;
  assign wb_wen     = wb_q.wen;
  assign wb_pc      = wb_q.pc;
  assign wb_src     = wb_src_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] grant_cnt_q [p_num_pipes];
  logic [31:0] grant_cnt_d [p_num_pipes];
  logic [31:0] stall_cnt_q [p_num_pipes];
  logic [31:0] stall_cnt_d [p_num_pipes];

  always_comb begin
    perf_grant_cnt = '0;
    perf_stall_cnt = '0;
    for (int unsigned i = 0; i < p_num_pipes; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i] + 32'(ex_val[i] & ex_rdy[i]);
      stall_cnt_d[i] = stall_cnt_q[i] + 32'(ex_val[i] & !ex_rdy[i]);
      perf_grant_cnt[i*32 +: 32] = grant_cnt_q[i];
      perf_stall_cnt[i*32 +: 32] = stall_cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < p_num_pipes; i++) begin
      if (!rst) begin
        grant_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end else begin
        grant_cnt_q[i] <= grant_cnt_d[i];
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
    end
  end
`else
  // Counters are absent in this build; arbitration is unaffected either way.
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int N  = 4;
  localparam int SB = 5;
  localparam int PB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     ex_val, ex_rdy, ex_wen;
  logic [N*SB-1:0]  ex_seq_num;
  logic [N*PB-1:0]  ex_preg;
  logic [N*5-1:0]   ex_waddr;
  logic [N*32-1:0]  ex_wdata, ex_pc;
  logic             wb_val, wb_rdy, wb_wen;
  logic [SB-1:0]    wb_seq_num;
  logic [PB-1:0]    wb_preg;
  logic [4:0]       wb_waddr;
  logic [31:0]      wb_wdata, wb_pc;
  logic [N-1:0]     wb_src;
`ifdef WB_ARB_PERF_EN
  logic [N*32-1:0]  perf_grant_cnt, perf_stall_cnt;
`endif

  // per-pipe stimulus, packed onto the flat DUT buses
  logic [SB-1:0] t_seq   [N];
  logic [PB-1:0] t_preg  [N];
  logic [4:0]    t_waddr [N];
  logic [31:0]   t_wdata [N];
  logic [31:0]   t_pc    [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ex_seq_num[i*SB +: SB] = t_seq[i];
      ex_preg[i*PB +: PB]    = t_preg[i];
      ex_waddr[i*5 +: 5]     = t_waddr[i];
      ex_wdata[i*32 +: 32]   = t_wdata[i];
      ex_pc[i*32 +: 32]      = t_pc[i];
    end
  end

  writeback_arbiter #(
    .p_num_pipes      (N),
    .p_seq_num_bits   (SB),
    .p_phys_addr_bits (PB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_val     (ex_val),
    .ex_rdy     (ex_rdy),
    .ex_seq_num (ex_seq_num),
    .ex_preg    (ex_preg),
    .ex_waddr   (ex_waddr),
    .ex_wdata   (ex_wdata),
    .ex_wen     (ex_wen),
    .ex_pc      (ex_pc),
    .wb_val     (wb_val),
    .wb_rdy     (wb_rdy),
    .wb_seq_num (wb_seq_num),
    .wb_preg    (wb_preg),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .wb_wen     (wb_wen),
    .wb_pc      (wb_pc),
    .wb_src     (wb_src)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int          m_ptr;
  logic        m_val;
  logic [SB-1:0] m_seq;
  logic [PB-1:0] m_preg;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_pc;
  logic        m_wen;
  logic [N-1:0] m_src;
  logic [31:0] m_gcnt [N];
  logic [31:0] m_scnt [N];

  // Which pipe the rules allow to transfer right now (one-hot, or zero).
  function automatic logic [N-1:0] model_rdy();
    if (rst !== 1'b1) return '0;
    if (m_val && !wb_rdy) return '0;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (ex_val[p]) return N'(1 << p);
    end
    return '0;
  endfunction

  function automatic void model_clock();
    logic [N-1:0] r;
    r = model_rdy();
    if (rst !== 1'b1) begin
      m_ptr = 0; m_val = 0; m_seq = '0; m_preg = '0; m_waddr = '0;
      m_wdata = '0; m_wen = 0; m_pc = '0; m_src = '0;
      for (int i = 0; i < N; i++) begin m_gcnt[i] = '0; m_scnt[i] = '0; end
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (ex_val[i] && r[i]) m_gcnt[i] = m_gcnt[i] + 1;
      if (ex_val[i] && !r[i]) m_scnt[i] = m_scnt[i] + 1;
    end
    if (r != '0) begin
      for (int g = 0; g < N; g++) begin
        if (r[g]) begin
          m_val = 1; m_seq = t_seq[g]; m_preg = t_preg[g]; m_waddr = t_waddr[g];
          m_wdata = t_wdata[g]; m_wen = ex_wen[g]; m_pc = t_pc[g];
          m_src = N'(1 << g);
          m_ptr = (g + 1) % N;
        end
      end
    end else if (wb_rdy) begin
      m_val = 0;
    end
  endfunction

  function automatic logic [85:0] exp_wb();
    return {m_val, m_seq, m_preg, m_waddr, m_wdata, m_wen, m_pc, m_src};
  endfunction

  function automatic logic [85:0] act_wb();
    return {wb_val, wb_seq_num, wb_preg, wb_waddr, wb_wdata, wb_wen, wb_pc, wb_src};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      t_seq[i]   = SB'($urandom);
      t_preg[i]  = PB'($urandom);
      t_waddr[i] = 5'($urandom);
      t_wdata[i] = $urandom;
      t_pc[i]    = $urandom;
    end
    ex_wen = N'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; ex_val = '0; wb_rdy = 1'b1; rand_fields();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (ex_rdy !== '0) begin errors++; $display("FAIL reset_rdy: ex_rdy=%b expected 0000", ex_rdy); end
      tick();
    end
    checks++;
    if (wb_val !== 1'b0 || wb_src !== '0) begin
      errors++; $display("FAIL reset_out: wb_val=%b wb_src=%b expected 0 0000", wb_val, wb_src);
    end
    checks++;
    if (act_wb() !== exp_wb()) begin errors++; $display("FAIL reset_fields: got %h expected %h", act_wb(), exp_wb()); end
    ex_val = 4'b1111; #1;
    checks++;
    if (ex_rdy !== '0) begin errors++; $display("FAIL reset_rdy_busy: ex_rdy=%b expected 0000", ex_rdy); end
    tick();
    rst = 1'b1; ex_val = 4'b0010; #1;
    checks++;
    if (ex_rdy !== 4'b0010) begin errors++; $display("FAIL idle_rdy: ex_rdy=%b expected 0010", ex_rdy); end
    tick();
    checks++;
    if (wb_val !== 1'b1 || wb_src !== 4'b0010) begin
      errors++; $display("FAIL idle_out: wb_val=%b wb_src=%b expected 1 0010", wb_val, wb_src);
    end
  endtask

  task automatic test_single();
    rand_fields();
    ex_val = 4'b0100; wb_rdy = 1'b1; t_seq[2] = 5'd7; t_wdata[2] = 32'hDEADBEEF; #1;
    checks++;
    if (ex_rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy: ex_rdy=%b expected 0100", ex_rdy); end
    tick();
    checks++;
    if (wb_val !== 1'b1 || wb_seq_num !== 5'd7 || wb_wdata !== 32'hDEADBEEF || wb_src !== 4'b0100) begin
      errors++;
      $display("FAIL single_out: val=%b seq=%0d wdata=%h src=%b expected 1 7 deadbeef 0100",
               wb_val, wb_seq_num, wb_wdata, wb_src);
    end
    checks++;
    if (act_wb() !== exp_wb()) begin errors++; $display("FAIL single_fields: got %h expected %h", act_wb(), exp_wb()); end
    ex_val = 4'b1111; #1;
    checks++;
    if (ex_rdy !== 4'b1000) begin errors++; $display("FAIL single_ptr: ex_rdy=%b expected 1000", ex_rdy); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    ex_val = 4'b1111; wb_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rand_fields(); #1;
      checks++;
      if (ex_rdy !== N'(1 << (k % N))) begin
        errors++; $display("FAIL rr_rdy step %0d: ex_rdy=%b expected %b", k, ex_rdy, N'(1 << (k % N)));
      end
      tick();
      checks++;
      if (wb_val !== 1'b1 || wb_src !== N'(1 << (k % N)) || act_wb() !== exp_wb()) begin
        errors++; $display("FAIL rr_out step %0d: got %h expected %h", k, act_wb(), exp_wb());
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ex_val = 4'b0011; wb_rdy = 1'b0; rand_fields(); #1;
    checks++;
    if (ex_rdy !== 4'b0001) begin errors++; $display("FAIL bp_first_rdy: ex_rdy=%b expected 0001", ex_rdy); end
    tick();
    for (int c = 0; c < 3; c++) begin
      rand_fields(); #1;
      checks++;
      if (ex_rdy !== '0) begin errors++; $display("FAIL bp_rdy cycle %0d: ex_rdy=%b expected 0000", c, ex_rdy); end
      tick();
      checks++;
      if (wb_src !== 4'b0001 || act_wb() !== exp_wb()) begin
        errors++; $display("FAIL bp_hold cycle %0d: got %h expected %h", c, act_wb(), exp_wb());
      end
    end
    wb_rdy = 1'b1; #1;
    checks++;
    if (ex_rdy !== 4'b0010) begin errors++; $display("FAIL bp_refill_rdy: ex_rdy=%b expected 0010", ex_rdy); end
    tick();
    checks++;
    if (wb_val !== 1'b1 || wb_src !== 4'b0010 || act_wb() !== exp_wb()) begin
      errors++; $display("FAIL bp_refill_out: got %h expected %h", act_wb(), exp_wb());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ex_val = 4'b0100; wb_rdy = 1'b1; rand_fields();
    tick();
    ex_val = 4'b1001; rand_fields(); #1;
    checks++;
    if (ex_rdy !== 4'b1000) begin errors++; $display("FAIL wrap_rdy3: ex_rdy=%b expected 1000", ex_rdy); end
    tick();
    checks++;
    if (wb_src !== 4'b1000 || act_wb() !== exp_wb()) begin
      errors++; $display("FAIL wrap_out3: got %h expected %h", act_wb(), exp_wb());
    end
    rand_fields(); #1;
    checks++;
    if (ex_rdy !== 4'b0001) begin errors++; $display("FAIL wrap_rdy0: ex_rdy=%b expected 0001", ex_rdy); end
    tick();
    checks++;
    if (wb_src !== 4'b0001 || act_wb() !== exp_wb()) begin
      errors++; $display("FAIL wrap_out0: got %h expected %h", act_wb(), exp_wb());
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ex_val = 4'b0010; wb_rdy = 1'b1; rand_fields();
    tick();
    ex_val = 4'b0000; wb_rdy = 1'b0;
    tick();
    rst = 1'b0; ex_val = 4'b1111; #1;
    checks++;
    if (ex_rdy !== '0) begin errors++; $display("FAIL midrst_rdy: ex_rdy=%b expected 0000", ex_rdy); end
    tick();
    checks++;
    if (wb_val !== 1'b0 || act_wb() !== exp_wb()) begin
      errors++; $display("FAIL midrst_out: got %h expected %h", act_wb(), exp_wb());
    end
`ifdef WB_ARB_PERF_EN
    checks++;
    if (perf_grant_cnt !== '0 || perf_stall_cnt !== '0) begin
      errors++; $display("FAIL midrst_perf: grant=%h stall=%h expected 0", perf_grant_cnt, perf_stall_cnt);
    end
`endif
    rst = 1'b1; #1;
    checks++;
    if (ex_rdy !== 4'b0001) begin errors++; $display("FAIL midrst_ptr: ex_rdy=%b expected 0001", ex_rdy); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      ex_val = N'($urandom);
      wb_rdy = ($urandom_range(0, 3) != 0);
      rand_fields(); #1;
      checks++;
      if (ex_rdy !== model_rdy()) begin
        errors++; $display("FAIL rand_rdy cycle %0d: ex_rdy=%b expected %b", c, ex_rdy, model_rdy());
      end
      tick();
      checks++;
      if (act_wb() !== exp_wb()) begin
        errors++; $display("FAIL rand_out cycle %0d: got %h expected %h", c, act_wb(), exp_wb());
      end
    end
    rst = 1'b1;
`ifdef WB_ARB_PERF_EN
    for (int i = 0; i < N; i++) begin
      checks++;
      if (perf_grant_cnt[i*32 +: 32] !== m_gcnt[i] || perf_stall_cnt[i*32 +: 32] !== m_scnt[i]) begin
        errors++;
        $display("FAIL rand_perf pipe %0d: grant=%0d stall=%0d expected %0d %0d", i,
                 perf_grant_cnt[i*32 +: 32], perf_stall_cnt[i*32 +: 32], m_gcnt[i], m_scnt[i]);
      end
    end
`endif
  endtask

  initial begin
    m_ptr = 0; m_val = 0; m_src = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
